// File: rtl/filtro_pa_ctrl.sv
// Sequencer for a 2nd-order IIR filter datapath (direct form II) with one shared multiply-accumulate unit.
// Latency: start edge to done is 7 clocks; back-to-back samples every 7 clocks (start may coincide with done).
// Backpressure: none; a start while busy is dropped and sets the sticky overrun flag.
module filtro_pa_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       en1,
   output logic       en2,
   output logic       en3,
   output logic       en4,
   output logic       en5,
   output logic       en6,
   output logic       en7,
   output logic [2:0] selmuxS,
   output logic [1:0] selmuxC,
   output logic [2:0] selmuxZ,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      F1    = 3'd1,
      F2    = 3'd2,
      Y1    = 3'd3,
      Y2    = 3'd4,
      Y3    = 3'd5,
      SHIFT = 3'd6
   } state_t;

   // Everything the datapath needs for one cycle, kept together so it is registered as a unit.
   typedef struct packed {
      logic [7:1] en;
      logic [2:0] s;
      logic [1:0] c;
      logic [2:0] z;
   } ctl_t;

   // Signal mux codes
   localparam logic [2:0] S_FK  = 3'd0;
   localparam logic [2:0] S_FK1 = 3'd1;
   localparam logic [2:0] S_FK2 = 3'd2;

   // Coefficient mux codes (b2 equals b0, so the b0 code serves both taps)
   localparam logic [1:0] C_NA1 = 2'd0;
   localparam logic [1:0] C_NA2 = 2'd1;
   localparam logic [1:0] C_B0  = 2'd2;
   localparam logic [1:0] C_B1  = 2'd3;

   // Addend mux codes
   localparam logic [2:0] Z_ZERO  = 3'd0;
   localparam logic [2:0] Z_ACUM1 = 3'd1;
   localparam logic [2:0] Z_ACUM2 = 3'd2;
   localparam logic [2:0] Z_ACUM3 = 3'd3;
   localparam logic [2:0] Z_UK    = 3'd4;

   // Fixed step schedule; any encoding outside it falls back to IDLE.
   function automatic state_t next_of(input state_t st, input logic go);
      state_t n;
      case (st)
         IDLE:    n = go ? F1 : IDLE;
         F1:      n = F2;
         F2:      n = Y1;
         Y1:      n = Y2;
         Y2:      n = Y3;
         Y3:      n = SHIFT;
         SHIFT:   n = IDLE;
         default: n = IDLE;
      endcase
      return n;
   endfunction

   // Moore decode: the datapath controls belonging to each state.
   function automatic ctl_t decode(input state_t st);
      ctl_t c;
      c = '0;
      case (st)
         F1: begin          // acum1 = -a1*fk1 + uk
            c.en[5] = 1'b1;
            c.s     = S_FK1;
            c.c     = C_NA1;
            c.z     = Z_UK;
         end
         F2: begin          // fk = -a2*fk2 + acum1
            c.en[2] = 1'b1;
            c.s     = S_FK2;
            c.c     = C_NA2;
            c.z     = Z_ACUM1;
         end
         Y1: begin          // acum2 = b0*fk
            c.en[6] = 1'b1;
            c.s     = S_FK;
            c.c     = C_B0;
            c.z     = Z_ZERO;
         end
         Y2: begin          // acum3 = b1*fk1 + acum2
            c.en[7] = 1'b1;
            c.s     = S_FK1;
            c.c     = C_B1;
            c.z     = Z_ACUM2;
         end
         Y3: begin          // yk = b2*fk2 + acum3
            c.en[1] = 1'b1;
            c.s     = S_FK2;
            c.c     = C_B0;
            c.z     = Z_ACUM3;
         end
         SHIFT: begin       // fk1 <= fk and fk2 <= old fk1 on the same edge
            c.en[3] = 1'b1;
            c.en[4] = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t state;
   ctl_t   ctl;

   // FSM with registered outputs: controls are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         ctl     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= next_of(state, start);
         ctl   <= decode(next_of(state, start));
         busy  <= (next_of(state, start) != IDLE);
         done  <= (state == SHIFT);
         if (start && (state != IDLE))
            overrun <= 1'b1;
      end
   end

   assign en1     = ctl.en[1];
   assign en2     = ctl.en[2];
   assign en3     = ctl.en[3];
   assign en4     = ctl.en[4];
   assign en5     = ctl.en[5];
   assign en6     = ctl.en[6];
   assign en7     = ctl.en[7];
   assign selmuxS = ctl.s;
   assign selmuxC = ctl.c;
   assign selmuxZ = ctl.z;

endmodule

// File: doc/filtro_pa_ctrl.md
FILTRO_PA_CTRL -- requirements
Module: filtro_pa_ctrl

Interface
REQ-001 Parameters: none; all mux codes and the step schedule are fixed by this document.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 start  input  1  sample strobe; requests one filter evaluation for the current uk.
REQ-005 en1..en7  output  1 each  register enables: en1 yk, en2 fk, en3 fk1, en4 fk2, en5 acum1, en6 acum2, en7 acum3.
REQ-006 selmuxS  output  3  signal select: 0 fk, 1 fk1, 2 fk2, 3 uk.
REQ-007 selmuxC  output  2  coefficient select: 0 (-a1), 1 (-a2), 2 b0 (=b2), 3 b1.
REQ-008 selmuxZ  output  3  addend select: 0 zero, 1 acum1, 2 acum2, 3 acum3, 4 uk, 5 yk.
REQ-009 busy  output  1  high while an evaluation is in progress (any state other than IDLE).
REQ-010 done  output  1  one-cycle pulse; yk holds the new output sample.
REQ-011 overrun  output  1  sticky flag; start arrived while busy.

Function
REQ-012 The FSM SHALL have states IDLE, F1, F2, Y1, Y2, Y3, SHIFT; it SHALL advance exactly one state per clock with no wait states.
REQ-013 IDLE -> F1 when start=1 at a rising edge; otherwise IDLE SHALL hold.
REQ-014 The sequence F1->F2->Y1->Y2->Y3->SHIFT->IDLE SHALL be unconditional.
REQ-015 All en and sel outputs SHALL be Moore outputs decoded from the state only; unlisted enables are 0.
REQ-016 F1: S=1 C=0 Z=4, en5=1 (acum1 = -a1*fk1 + uk).
REQ-017 F2: S=2 C=1 Z=1, en2=1 (fk = -a2*fk2 + acum1).
REQ-018 Y1: S=0 C=2 Z=0, en6=1 (acum2 = b0*fk).
REQ-019 Y2: S=1 C=3 Z=2, en7=1 (acum3 = b1*fk1 + acum2).
REQ-020 Y3: S=2 C=2 Z=3, en1=1 (yk = b2*fk2 + acum3).
REQ-021 SHIFT: en3=1 and en4=1 together, so that fk1<=fk and fk2<=old fk1 on the same edge.
REQ-022 IDLE: all enables 0; selmuxS=0, selmuxC=0, selmuxZ=0.
REQ-023 done SHALL be registered and high for exactly the one cycle following SHIFT (the FSM is in IDLE in that cycle).
REQ-024 Latency: the start edge is edge 0; done SHALL be high during the cycle after edge 6, giving a 7-cycle throughput.
REQ-025 A start that coincides with done=1 SHALL be accepted (IDLE->F1), allowing back-to-back samples every 7 cycles.
REQ-026 start while busy=1 SHALL be ignored; it SHALL set overrun, and the sequence in progress SHALL be unaffected.
REQ-027 overrun SHALL clear only on reset.
REQ-028 uk SHALL be held stable by the source from the start edge through the F1 cycle; the controller does not latch uk.
REQ-029 Illegal or unreachable state encodings SHALL return to IDLE on the next edge with all enables 0.

Reset
REQ-030 With reset=0 at a rising edge, the next state SHALL be IDLE and busy, done and overrun SHALL be 0; this applies in any state, including mid-sequence.
REQ-031 No enable SHALL be asserted in the cycle following a reset edge.
REQ-032 start SHALL be ignored while reset=0.
REQ-033 Datapath register contents are reset by the datapath; the controller does not reset them.

Verification
REQ-034 Single sample: pulse start for 1 cycle from IDLE -> the states F1..SHIFT appear in consecutive cycles with the exact S/C/Z/en codes of REQ-016..021; done pulses at cycle 7; busy is high for cycles 1-6.
REQ-035 Back-to-back: raise start on every done pulse for 4 samples -> F1 follows each done with no gap, done arrives every 7 cycles, and overrun stays 0.
REQ-036 Overrun: start in IDLE, then start again during Y1 -> the sequence completes unchanged, overrun=1 and stays high until reset.
REQ-037 Reset mid-sequence: assert reset=0 during Y2 -> the next cycle is IDLE with all enables 0, no done pulse, and overrun=0.
REQ-038 End-to-end with the datapath, coefficients -a1=0, -a2=0, b0=1, b1=0: apply uk=100 then uk=0 -> yk=100, then yk=0; after the first SHIFT, fk1=100 and fk2=0.
REQ-039 Impulse with b1=-2, b0=1: uk=1,0,0,0 -> yk sequence 1, -2, 1, 0 (checks that the shift ordering is correct).
